// File: rtl/decode_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl_stage
// Purpose  : Registered RV32I/RV64I decode-and-control stage. Decodes R-type,
//            I-type ALU, LOAD, STORE and LUI into ALU op, write enable,
//            immediate and register indices, holds the bundle in a one-entry
//            valid/ready register with flush, and counts illegal encodings.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_aluop,
  output logic             out_regwen,
  output logic             out_alusrc,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_xor  = 4'b0011;
  localparam logic [3:0] c_op_sll  = 4'b0100;
  localparam logic [3:0] c_op_srl  = 4'b0101;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_sra  = 4'b0111;
  localparam logic [3:0] c_op_slt  = 4'b1000;
  localparam logic [3:0] c_op_sltu = 4'b1001;
  localparam logic [3:0] c_op_ill  = 4'b1111;

  localparam logic [6:0] c_opc_r     = 7'b0110011;
  localparam logic [6:0] c_opc_i     = 7'b0010011;
  localparam logic [6:0] c_opc_load  = 7'b0000011;
  localparam logic [6:0] c_opc_store = 7'b0100011;
  localparam logic [6:0] c_opc_lui   = 7'b0110111;

  localparam logic c_is_rv64 = (XLEN == 64);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [6:0]      w_shift_hi;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_u;
  logic            w_accept;

  logic [3:0]      w_aluop;
  logic            w_regwen;
  logic            w_alusrc;
  logic [XLEN-1:0] w_imm;
  logic [4:0]      w_rs1;
  logic            w_legal;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];

  assign w_imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};

  // RV64 shift immediates use a 6-bit shamt, so bit 25 belongs to the shamt
  // and only inst[31:26] is the function field; it is padded to line up with
  // the 7-bit RV32 encoding so one comparison serves both widths.
  generate
    if (XLEN == 64) begin : g_rv64
      assign w_shift_hi = {in_inst[31:26], 1'b0};
      assign w_imm_u    = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
    end else begin : g_rv32
      assign w_shift_hi = in_inst[31:25];
      assign w_imm_u    = {in_inst[31:12], 12'b0};
    end
  endgenerate

  assign in_ready = !flush && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Combinational decode of the incoming instruction
  always_comb begin
    w_aluop  = c_op_add;
    w_regwen = 1'b0;
    w_alusrc = 1'b0;
    w_imm    = '0;
    w_rs1    = in_inst[19:15];
    w_legal  = 1'b0;
    case (w_opcode)
      c_opc_r: begin
        w_regwen = 1'b1;
        w_legal  = 1'b1;
        case ({w_f7, w_f3})
          {7'b0000000, 3'b000}: w_aluop = c_op_add;
          {7'b0000000, 3'b001}: w_aluop = c_op_sll;
          {7'b0000000, 3'b010}: w_aluop = c_op_slt;
          {7'b0000000, 3'b011}: w_aluop = c_op_sltu;
          {7'b0000000, 3'b100}: w_aluop = c_op_xor;
          {7'b0000000, 3'b101}: w_aluop = c_op_srl;
          {7'b0000000, 3'b110}: w_aluop = c_op_or;
          {7'b0000000, 3'b111}: w_aluop = c_op_and;
          {7'b0100000, 3'b000}: w_aluop = c_op_sub;
          {7'b0100000, 3'b101}: w_aluop = c_op_sra;
          default:              w_legal = 1'b0;
        endcase
      end
      c_opc_i: begin
        w_regwen = 1'b1;
        w_alusrc = 1'b1;
        w_imm    = w_imm_i;
        w_legal  = 1'b1;
        case (w_f3)
          3'b000: w_aluop = c_op_add;
          3'b010: w_aluop = c_op_slt;
          3'b011: w_aluop = c_op_sltu;
          3'b100: w_aluop = c_op_xor;
          3'b110: w_aluop = c_op_or;
          3'b111: w_aluop = c_op_and;
          3'b001: begin
            w_aluop = c_op_sll;
            w_legal = (w_shift_hi == 7'b0000000);
          end
          default: begin
            if (w_shift_hi == 7'b0100000) begin
              w_aluop = c_op_sra;
            end else begin
              w_aluop = c_op_srl;
              w_legal = (w_shift_hi == 7'b0000000);
            end
          end
        endcase
      end
      c_opc_load: begin
        w_regwen = 1'b1;
        w_alusrc = 1'b1;
        w_imm    = w_imm_i;
        case (w_f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
          3'b011, 3'b110:                         w_legal = c_is_rv64;
          default:                                w_legal = 1'b0;
        endcase
      end
      c_opc_store: begin
        w_alusrc = 1'b1;
        w_imm    = w_imm_s;
        w_legal  = (w_f3 < 3'b011) || ((w_f3 == 3'b011) && c_is_rv64);
      end
      c_opc_lui: begin
        w_regwen = 1'b1;
        w_alusrc = 1'b1;
        w_imm    = w_imm_u;
        w_rs1    = 5'd0;
        w_legal  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      w_aluop  = c_op_ill;
      w_regwen = 1'b0;
      w_alusrc = 1'b0;
      w_imm    = '0;
    end
    // Writes to x0 are architecturally discarded
    if (in_inst[11:7] == 5'd0) begin
      w_regwen = 1'b0;
    end
  end

  // Pipeline register: valid flag with flush priority, payload loads on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_aluop   <= c_op_ill;
      out_regwen  <= 1'b0;
      out_alusrc  <= 1'b0;
      out_imm     <= '0;
      out_rs1     <= 5'd0;
      out_rs2     <= 5'd0;
      out_rd      <= 5'd0;
      out_illegal <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (w_accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        out_aluop   <= w_aluop;
        out_regwen  <= w_regwen;
        out_alusrc  <= w_alusrc;
        out_imm     <= w_imm;
        out_rs1     <= w_rs1;
        out_rs2     <= in_inst[24:20];
        out_rd      <= in_inst[11:7];
        out_illegal <= !w_legal;
      end
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (w_accept && !w_legal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
